// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared FSM encoding, register offsets and synchronizer idle level
package cpu_bus_pkg;
  typedef enum logic [1:0] {WAIT_IDLE, IDLE, LOW_CNT, ARMED} state_t;
  localparam logic [1:0] OFS_REG1 = 2'd0;
  localparam logic [1:0] OFS_REG2 = 2'd1;
  localparam logic [1:0] OFS_REG3 = 2'd2;
  localparam logic SYNC_IDLE = 1'b1;
  function automatic logic [2:0] ofs_onehot(input logic [1:0] ofs);
    return {ofs == OFS_REG3, ofs == OFS_REG2, ofs == OFS_REG1};
  endfunction
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer with synchronous reset to a chosen level
module sync2 #(
  parameter int W = 1,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s1;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= RST_VAL;
      q  <= RST_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/cpu_wr_front.sv
// cpu_wr_front: synchronizes and filters the CPU write strobe, decodes and issues register-bank writes
module cpu_wr_front
  import cpu_bus_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 4,
  parameter logic [AW-1:0] BASE_ADDR = '0,
  parameter int MIN_LOW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_wr_n,
  input  logic          cpu_cs_n,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_data,
  output logic          my_wr,
  output logic          CS_reg1,
  output logic          CS_reg2,
  output logic          CS_reg3,
  output logic [DW-1:0] data_out,
  output logic          wr_err
);
  localparam logic [3:0] MIN_LOW_C = 4'(MIN_LOW);
  logic wr_s2, cs_s2;
  sync2 #(.W(2), .RST_VAL({SYNC_IDLE, SYNC_IDLE})) u_sync (
    .clk(clk),
    .rst(rst),
    .d({cpu_wr_n, cpu_cs_n}),
    .q({wr_s2, cs_s2})
  );
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [AW-1:0] sh_addr, sh_addr_nx;
  logic [DW-1:0] sh_data, sh_data_nx, data_nx;
  logic sh_cs, sh_cs_nx, my_wr_nx, wr_err_nx;
  logic [2:0] cs_nx;
  logic hit;
  assign hit = sh_addr[AW-1:2] == BASE_ADDR[AW-1:2] && sh_addr[1:0] != 2'd3;
  // WAIT_IDLE reuses the counter to demand three consecutive high samples, so the
  // synchronizer's reset-level ones cannot pass off a strobe held low across reset
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    sh_addr_nx = sh_addr;
    sh_data_nx = sh_data;
    sh_cs_nx   = sh_cs;
    my_wr_nx   = 1'b0;
    wr_err_nx  = 1'b0;
    cs_nx      = {CS_reg3, CS_reg2, CS_reg1};
    data_nx    = data_out;
    case (state)
      WAIT_IDLE: begin
        cnt_nx   = wr_s2 ? cnt + 4'd1 : 4'd0;
        state_nx = (wr_s2 && cnt == 4'd2) ? IDLE : WAIT_IDLE;
      end
      IDLE: if (!wr_s2) begin
        cnt_nx   = 4'd1;
        state_nx = LOW_CNT;
      end
      LOW_CNT: if (wr_s2) state_nx = IDLE;
      else begin
        cnt_nx   = cnt + 4'd1;
        state_nx = (cnt + 4'd1 >= MIN_LOW_C) ? ARMED : LOW_CNT;
      end
      ARMED: if (!wr_s2) begin
        sh_addr_nx = cpu_addr;
        sh_data_nx = cpu_data;
        sh_cs_nx   = cs_s2;
      end else begin
        state_nx  = IDLE;
        my_wr_nx  = !sh_cs && hit;
        wr_err_nx = !sh_cs && !hit;
        cs_nx     = my_wr_nx ? ofs_onehot(sh_addr[1:0]) : cs_nx;
        data_nx   = my_wr_nx ? sh_data : data_out;
      end
      default: state_nx = WAIT_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= WAIT_IDLE;
      cnt      <= '0;
      sh_addr  <= '0;
      sh_data  <= '0;
      sh_cs    <= 1'b0;
      my_wr    <= 1'b0;
      wr_err   <= 1'b0;
      {CS_reg3, CS_reg2, CS_reg1} <= '0;
      data_out <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      sh_addr  <= sh_addr_nx;
      sh_data  <= sh_data_nx;
      sh_cs    <= sh_cs_nx;
      my_wr    <= my_wr_nx;
      wr_err   <= wr_err_nx;
      {CS_reg3, CS_reg2, CS_reg1} <= cs_nx;
      data_out <= data_nx;
    end
  end
endmodule

// File: tb/tb_cpu_wr_front.sv
// tb_cpu_wr_front: vector table, corner sequences and randomized strobes against a transaction-level model
module tb_cpu_wr_front;
  logic clk = 0, rst = 1;
  logic cpu_wr_n = 1, cpu_cs_n = 1;
  logic [3:0] cpu_addr = '0;
  logic [7:0] cpu_data = '0;
  logic my_wr, CS_reg1, CS_reg2, CS_reg3, wr_err;
  logic [7:0] data_out;

  cpu_wr_front dut (
    .clk(clk), .rst(rst), .cpu_wr_n(cpu_wr_n), .cpu_cs_n(cpu_cs_n),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data), .my_wr(my_wr),
    .CS_reg1(CS_reg1), .CS_reg2(CS_reg2), .CS_reg3(CS_reg3),
    .data_out(data_out), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;
  int cyc = 0, rel_cyc = 0, last_lat = -1, err_cnt = 0;
  logic [10:0] wr_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (my_wr) begin
        wr_q.push_back({CS_reg3, CS_reg2, CS_reg1, data_out});
        last_lat = cyc - rel_cyc;
        chk("onehot", 32'($countones({CS_reg3, CS_reg2, CS_reg1})), 32'd1);
      end
      if (wr_err) err_cnt++;
    end
  end

  task automatic strobe(input int low, input logic cs, input logic [3:0] a, input logic [7:0] d, input int gap);
    cpu_cs_n = cs;
    cpu_addr = a;
    cpu_data = d;
    cpu_wr_n = 0;
    repeat (low) @(posedge clk);
    #1 cpu_wr_n = 1;
    rel_cyc = cyc;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_q.delete();
    err_cnt = 0;
    last_lat = -1;
  endtask

  typedef struct {
    int low; logic cs; logic [3:0] addr; logic [7:0] data;
    int exp_wr; int exp_err; logic [2:0] exp_cs; logic [7:0] exp_data;
  } vec_t;
  vec_t vt[9];

  logic [10:0] exp_q[$];
  int exp_err;

  initial begin
    vt[0] = '{6, 1'b0, 4'h1, 8'hA5, 1, 0, 3'b010, 8'hA5};
    vt[1] = '{1, 1'b0, 4'h2, 8'hFF, 0, 0, 3'b010, 8'hA5};
    vt[2] = '{6, 1'b0, 4'h3, 8'h5A, 0, 1, 3'b010, 8'hA5};
    vt[3] = '{6, 1'b1, 4'h0, 8'h77, 0, 0, 3'b010, 8'hA5};
    vt[4] = '{6, 1'b0, 4'h4, 8'h77, 0, 1, 3'b010, 8'hA5};
    vt[5] = '{3, 1'b0, 4'h0, 8'h3C, 1, 0, 3'b001, 8'h3C};
    vt[6] = '{3, 1'b0, 4'h2, 8'hC3, 1, 0, 3'b100, 8'hC3};
    vt[7] = '{1, 1'b0, 4'h0, 8'h00, 0, 0, 3'b100, 8'hC3};
    vt[8] = '{4, 1'b0, 4'hF, 8'h99, 0, 1, 3'b100, 8'hC3};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {my_wr, wr_err, CS_reg3, CS_reg2, CS_reg1, data_out}, '0);
    rst = 0;
    repeat (6) @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      clear_log();
      strobe(vt[i].low, vt[i].cs, vt[i].addr, vt[i].data, 8);
      chk($sformatf("v%0d_nwr", i), wr_q.size(), vt[i].exp_wr);
      chk($sformatf("v%0d_nerr", i), err_cnt, vt[i].exp_err);
      chk($sformatf("v%0d_cs", i), {CS_reg3, CS_reg2, CS_reg1}, vt[i].exp_cs);
      chk($sformatf("v%0d_data", i), data_out, vt[i].exp_data);
      if (vt[i].exp_wr == 1) chk($sformatf("v%0d_latency", i), last_lat, 3);
    end

    // strobe held low through reset, released 10 cycles after reset deassertion
    clear_log();
    cpu_cs_n = 0; cpu_addr = 4'h1; cpu_data = 8'h55; cpu_wr_n = 0;
    repeat (5) @(posedge clk);
    #1 rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_outputs", {my_wr, wr_err, CS_reg3, CS_reg2, CS_reg1, data_out}, '0);
    rst = 0;
    repeat (10) @(posedge clk);
    #1 cpu_wr_n = 1;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_nwr", wr_q.size(), 0);
    chk("midrst_nerr", err_cnt, 0);
    strobe(6, 1'b0, 4'h0, 8'h3C, 8);
    chk("post_rst_nwr", wr_q.size(), 1);
    chk("post_rst_cs", {CS_reg3, CS_reg2, CS_reg1}, 3'b001);
    chk("post_rst_data", data_out, 8'h3C);

    // strobe released right after reset deassertion
    clear_log();
    cpu_wr_n = 0;
    repeat (4) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(posedge clk);
    #1 cpu_wr_n = 1;
    repeat (10) @(posedge clk);
    #1;
    chk("early_release_nwr", wr_q.size() + err_cnt, 0);

    // back-to-back writes with the minimum two high cycles between them
    clear_log();
    strobe(6, 1'b0, 4'h0, 8'h11, 2);
    strobe(6, 1'b0, 4'h1, 8'h22, 2);
    strobe(6, 1'b0, 4'h2, 8'h33, 8);
    chk("b2b_nwr", wr_q.size(), 3);
    if (wr_q.size() == 3) begin
      chk("b2b_w0", wr_q[0], {3'b001, 8'h11});
      chk("b2b_w1", wr_q[1], {3'b010, 8'h22});
      chk("b2b_w2", wr_q[2], {3'b100, 8'h33});
    end
    chk("b2b_nerr", err_cnt, 0);

    // random strobes predicted transaction by transaction from the decode rules
    clear_log();
    exp_q.delete();
    exp_err = 0;
    for (int t = 0; t < 80; t++) begin
      int low, gap;
      logic cs;
      logic [3:0] a;
      logic [7:0] d;
      low = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(3, 8);
      gap = $urandom_range(2, 5);
      cs = ($urandom_range(0, 3) == 0);
      a = 4'($urandom);
      d = 8'($urandom);
      if (low >= 3 && !cs) begin
        if (a[3:2] == 2'b00 && a[1:0] != 2'd3) exp_q.push_back({3'b001 << a[1:0], d});
        else exp_err++;
      end
      strobe(low, cs, a, d, gap);
    end
    repeat (8) @(posedge clk);
    #1;
    chk("rand_nwr", wr_q.size(), exp_q.size());
    chk("rand_nerr", err_cnt, exp_err);
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      chk($sformatf("rand_w%0d", i), wr_q[i], exp_q[i]);
    if (exp_q.size() > 0)
      chk("rand_final_regs", {CS_reg3, CS_reg2, CS_reg1, data_out}, exp_q[exp_q.size()-1]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
